tty_ram_arbiter: RTL and testbench
==================================

// Module: tty_ram_arbiter
// PURPOSE
//  Shares one exported on-chip RAM port (ram1/ram2: 16b addr, 8b data) between two fabric masters.
//  M0 is the LCD text scanout fetch: read-only, latency-critical. M1 is the HPS-side/cursor update path: read/write.
//  Drives the RAM command from registers and tracks read latency.
//  Returns each read to the master that issued it.
// PARAMETERS
//  AW          16  RAM address width
//  DW          8   RAM data width
//  RD_LAT      1   RAM readdata latency, in cycles after the command cycle on the RAM port (1..3)
//  STARVE_MAX  15  max consecutive M0 grants while M1 is pending, before M1 is forced (1..255)
// PORTS
//  clk_clk        in   1   system clock (RAM clock domain)
//  reset_reset_n  in   1   asynchronous active-low reset
//  m0_req         in   1   M0 read request
//  m0_addr        in   AW  M0 address
//  m0_gnt         out  1   M0 request accepted this cycle
//  m0_rvalid      out  1   M0 read data valid
//  m0_rdata       out  DW  M0 read data
//  m1_req         in   1   M1 request
//  m1_write       in   1   1=write, 0=read
//  m1_addr        in   AW  M1 address
//  m1_wdata       in   DW  M1 write data
//  m1_gnt         out  1   M1 request accepted this cycle
//  m1_rvalid      out  1   M1 read data valid (reads only)
//  m1_rdata       out  DW  M1 read data
//  ram_address    out  AW  to RAM address
//  ram_chipselect out  1   to RAM chipselect
//  ram_clken      out  1   to RAM clken
//  ram_write      out  1   to RAM write
//  ram_writedata  out  DW  to RAM writedata
//  ram_readdata   in   DW  from RAM readdata
// BEHAVIOUR
//  - Reset values: all outputs 0. ram_clken goes 1 on the first clock after reset release and stays 1.
//  - Handshake: a master holds req and its fields stable until gnt. gnt is combinational from req and arbiter state.
//    At most one gnt per cycle. gnt is never asserted without req.
//  - Accepted request: registered onto ram_* the next cycle (issue cycle), with ram_chipselect=1 for exactly that cycle.
//    No accept in a cycle -> ram_chipselect=0 and ram_write=0 the next cycle. Address and data hold their last values.
//  - Throughput: one transfer per cycle. Back-to-back grants are legal, with no bubble.
//  - Read return: rvalid pulses RD_LAT cycles after the issue cycle; rdata = ram_readdata in that cycle.
//    Total latency from gnt to rvalid is 1+RD_LAT. rdata holds its value between pulses.
//  - Writes never produce rvalid.
//  - Tag pipe: RD_LAT-deep shift register of {valid, master} steers returns. Ordering is strictly in-order.
//  - Priority (default): M0 wins over M1. starve_cnt (8b) increments on each M0 grant while m1_req=1.
//    When starve_cnt==STARVE_MAX and m1_req=1, M1 is granted even if m0_req=1.
//    starve_cnt clears on any M1 grant and whenever m1_req=0.
//  - Simultaneous requests: exactly one grant, per the rule above. The loser keeps req and is served later.
//  - Read-after-write to the same address: M1 write then M1 read returns the new data, since the RAM is in-order.
//  - Reset mid-operation: the tag pipe clears, in-flight reads are dropped (no rvalid), and the counters clear.
// CONFIGURATION
//  TTY_ARB_RR_EN defined: replaces fixed priority with 2-way round-robin.
//   - last_gnt register is reset to M1.
//   - On contention, grant goes to the master not granted last; starve_cnt is not instantiated.
//  TTY_ARB_RR_EN undefined: fixed priority plus starvation limit, as in BEHAVIOUR.
// STRUCTURE
//  - Shared package tty_pkg: TTY_AW, TTY_DW constants; master-id enum (MST_DISP=0, MST_HOST=1); tag struct {vld, mst}.
//  - Sub-module tty_rd_tag_pipe: RD_LAT-deep tag shift register with async clear.
//    Arbitration and command register stay in the top module.
// TESTING
//  1. Reset: hold reset_reset_n=0, drive m0_req=1.
//     -> all outputs 0; ram_clken=1 on the first clock after release.
//  2. M0 only: reads at 0x0000, 0x0001, 0x0002 on consecutive cycles with RAM preloaded with 0x41, 0x42, 0x43.
//     -> gnt each cycle; m0_rvalid on 3 consecutive cycles, 2 cycles after each gnt (RD_LAT=1), data 0x41, 0x42, 0x43.
//  3. M1 write of 0x5A to 0x1234, then M1 read of 0x1234.
//     -> ram_write=1 for one cycle; m1_rvalid with 0x5A; no m0_rvalid.
//  4. Starvation: m0_req and m1_req held at 1, STARVE_MAX=15.
//     -> 15 M0 grants, then 1 M1 grant, repeating. No cycle has both gnts.
//  5. Reset mid-operation: assert reset 1 cycle after an M0 read gnt.
//     -> no m0_rvalid after release; tag pipe empty.
//  6. With TTY_ARB_RR_EN defined, both reqs held at 1.
//     -> grants alternate, starting M0, M1, M0 ...

Source files
------------

// File: rtl/tty_pkg.sv
// Shared constants and types for the TTY RAM arbiter: bus widths, master ids
// and the read-return tag carried alongside each RAM command.
package tty_pkg;

    localparam int TTY_AW = 16;
    localparam int TTY_DW = 8;

    typedef enum logic {
        MST_DISP = 1'b0,
        MST_HOST = 1'b1
    } mst_e;

    typedef struct packed {
        logic vld;
        mst_e mst;
    } tag_t;

    localparam tag_t TAG_IDLE = '{vld: 1'b0, mst: MST_DISP};

endpackage

// File: rtl/tty_rd_tag_pipe.sv
// RD_LAT-deep shift register of read tags; the output stage lines up with the
// cycle in which the RAM presents readdata for the tagged command.
module tty_rd_tag_pipe
    import tty_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage_r [RD_LAT];

    // Advance tags one stage per cycle; reset drops every read in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_r[i] <= TAG_IDLE;
            end
        end else begin
            stage_r[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign tag_out = stage_r[RD_LAT-1];

endmodule

// File: rtl/tty_ram_arbiter.sv
// Two-master arbiter for the exported TTY text RAM port. M0 (display scanout)
// reads only; M1 (host/cursor) reads and writes. Define TTY_ARB_RR_EN to
// replace fixed priority with starvation limit by two-way round-robin.
module tty_ram_arbiter
    import tty_pkg::*;
#(
    parameter int AW         = TTY_AW,
    parameter int DW         = TTY_DW,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 15
) (
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_write,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] ram_address,
    output logic          ram_chipselect,
    output logic          ram_clken,
    output logic          ram_write,
    output logic [DW-1:0] ram_writedata,
    input  logic [DW-1:0] ram_readdata
);

    logic          active_r;
    logic          m0_gnt_s;
    logic          m1_gnt_s;
    logic [AW-1:0] ram_address_r;
    logic          ram_chipselect_r;
    logic          ram_write_r;
    logic [DW-1:0] ram_writedata_r;
    mst_e          issue_mst_r;
    tag_t          issue_tag_s;
    tag_t          ret_tag_s;
    logic          m0_ret_s;
    logic          m1_ret_s;
    logic [DW-1:0] m0_rdata_r;
    logic [DW-1:0] m1_rdata_r;

    // Goes high one clock after reset release; also gates grants during reset
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            active_r <= 1'b0;
        end else begin
            active_r <= 1'b1;
        end
    end

`ifdef TTY_ARB_RR_EN
    mst_e last_gnt_r;

    // Round-robin grant: on contention the master not served last wins
    always_comb begin
        m0_gnt_s = 1'b0;
        m1_gnt_s = 1'b0;
        if (active_r) begin
            if (m0_req && m1_req) begin
                if (last_gnt_r == MST_HOST) begin
                    m0_gnt_s = 1'b1;
                end else begin
                    m1_gnt_s = 1'b1;
                end
            end else begin
                m0_gnt_s = m0_req;
                m1_gnt_s = m1_req;
            end
        end else begin
            m0_gnt_s = 1'b0;
            m1_gnt_s = 1'b0;
        end
    end

    // Track the most recent winner; starts at M1 so M0 wins the first tie
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            last_gnt_r <= MST_HOST;
        end else if (m0_gnt_s) begin
            last_gnt_r <= MST_DISP;
        end else if (m1_gnt_s) begin
            last_gnt_r <= MST_HOST;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end
`else
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0] starve_cnt_r;
    logic       m1_force_s;

    assign m1_force_s = m1_req && (starve_cnt_r == STARVE_LIM);

    // Fixed priority to M0 unless M1 has waited out STARVE_MAX M0 grants
    always_comb begin
        m0_gnt_s = 1'b0;
        m1_gnt_s = 1'b0;
        if (active_r) begin
            m1_gnt_s = m1_req && (!m0_req || m1_force_s);
            m0_gnt_s = m0_req && !m1_gnt_s;
        end else begin
            m0_gnt_s = 1'b0;
            m1_gnt_s = 1'b0;
        end
    end

    // Count M0 grants taken while M1 is waiting
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            starve_cnt_r <= 8'd0;
        end else if (!m1_req || m1_gnt_s) begin
            starve_cnt_r <= 8'd0;
        end else if (m0_gnt_s) begin
            starve_cnt_r <= starve_cnt_r + 8'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`endif

    // Register the accepted command; address and data hold when idle
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ram_address_r    <= '0;
            ram_chipselect_r <= 1'b0;
            ram_write_r      <= 1'b0;
            ram_writedata_r  <= '0;
            issue_mst_r      <= MST_DISP;
        end else begin
            ram_chipselect_r <= m0_gnt_s | m1_gnt_s;
            if (m1_gnt_s) begin
                ram_address_r   <= m1_addr;
                ram_write_r     <= m1_write;
                ram_writedata_r <= m1_wdata;
                issue_mst_r     <= MST_HOST;
            end else if (m0_gnt_s) begin
                ram_address_r <= m0_addr;
                ram_write_r   <= 1'b0;
                issue_mst_r   <= MST_DISP;
            end else begin
                ram_write_r <= 1'b0;
            end
        end
    end

    assign issue_tag_s = '{vld: ram_chipselect_r & ~ram_write_r, mst: issue_mst_r};

    tty_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .tag_in  (issue_tag_s),
        .tag_out (ret_tag_s)
    );

    assign m0_ret_s = ret_tag_s.vld && (ret_tag_s.mst == MST_DISP);
    assign m1_ret_s = ret_tag_s.vld && (ret_tag_s.mst == MST_HOST);

    // Hold the last returned byte per master between rvalid pulses
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            m0_rdata_r <= '0;
            m1_rdata_r <= '0;
        end else begin
            if (m0_ret_s) begin
                m0_rdata_r <= ram_readdata;
            end else begin
                m0_rdata_r <= m0_rdata_r;
            end
            if (m1_ret_s) begin
                m1_rdata_r <= ram_readdata;
            end else begin
                m1_rdata_r <= m1_rdata_r;
            end
        end
    end

    assign m0_gnt         = m0_gnt_s;
    assign m1_gnt         = m1_gnt_s;
    assign m0_rvalid      = m0_ret_s;
    assign m1_rvalid      = m1_ret_s;
    assign m0_rdata       = m0_ret_s ? ram_readdata : m0_rdata_r;
    assign m1_rdata       = m1_ret_s ? ram_readdata : m1_rdata_r;
    assign ram_address    = ram_address_r;
    assign ram_chipselect = ram_chipselect_r;
    assign ram_clken      = active_r;
    assign ram_write      = ram_write_r;
    assign ram_writedata  = ram_writedata_r;

endmodule

// File: tb/tb_tty_ram_arbiter.sv
// Scoreboard bench for tty_ram_arbiter: randomized and directed traffic is
// predicted by a behavioural model and checked by a separate output monitor.
module tb_tty_ram_arbiter;

    localparam int AW         = 16;
    localparam int DW         = 8;
    localparam int RD_LAT     = 1;
    localparam int STARVE_MAX = 15;

    logic          clk_clk = 1'b0;
    logic          reset_reset_n = 1'b0;
    logic          m0_req = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0;
    logic          m1_write = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic [AW-1:0] ram_address;
    logic          ram_chipselect;
    logic          ram_clken;
    logic          ram_write;
    logic [DW-1:0] ram_writedata;
    logic [DW-1:0] ram_readdata;

    tty_ram_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_address(ram_address), .ram_chipselect(ram_chipselect),
        .ram_clken(ram_clken), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
    );

    always #5 clk_clk = ~clk_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM behavioural model sitting on the exported port
    logic [7:0] ram_mem [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic [7:0] rd_pipe [RD_LAT];

    always @(posedge clk_clk) begin
        if (ram_chipselect && ram_clken && ram_write) ram_mem[ram_address] <= ram_writedata;
        rd_pipe[0] <= ram_mem[ram_address];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_readdata = rd_pipe[RD_LAT-1];

    // Scoreboard queues
    typedef struct { int due; logic [7:0] data; } rd_exp_t;
    typedef struct { int due; logic wr; logic [15:0] addr; logic [7:0] wd; } cmd_exp_t;
    rd_exp_t  q0[$];
    rd_exp_t  q1[$];
    cmd_exp_t qc[$];

    // Reference arbitration state
    bit m0_pend   = 1'b0;
    bit m1_pend   = 1'b0;
    int streak    = 0;
    bit last_host = 1'b1;

    rd_exp_t  mr;
    cmd_exp_t mc;

    // Output monitor: read returns and RAM command port
    always @(negedge clk_clk) begin
        if (m0_rvalid) begin
            if (q0.size() == 0) check("m0_rvalid_unexpected", m0_rvalid, 1'b0);
            else begin
                mr = q0.pop_front();
                check("m0_rvalid_cycle", cyc, mr.due);
                check("m0_rdata", m0_rdata, mr.data);
            end
        end else if (q0.size() > 0 && q0[0].due <= cyc) begin
            check("m0_rvalid_missing", m0_rvalid, 1'b1);
            void'(q0.pop_front());
        end
        if (m1_rvalid) begin
            if (q1.size() == 0) check("m1_rvalid_unexpected", m1_rvalid, 1'b0);
            else begin
                mr = q1.pop_front();
                check("m1_rvalid_cycle", cyc, mr.due);
                check("m1_rdata", m1_rdata, mr.data);
            end
        end else if (q1.size() > 0 && q1[0].due <= cyc) begin
            check("m1_rvalid_missing", m1_rvalid, 1'b1);
            void'(q1.pop_front());
        end
        if (qc.size() > 0 && qc[0].due == cyc) begin
            mc = qc.pop_front();
            check("ram_cmd_cs_we", {ram_chipselect, ram_write}, {1'b1, mc.wr});
            check("ram_cmd_addr", ram_address, mc.addr);
            if (mc.wr) check("ram_cmd_wdata", ram_writedata, mc.wd);
        end else begin
            check("ram_idle_cs_we", {ram_chipselect, ram_write}, 2'b00);
        end
    end

    // One cycle of stimulus plus reference grant prediction
    task automatic drive_cycle(input bit n0, input logic [15:0] a0, input bit n1, input bit w1,
                               input logic [15:0] a1, input logic [7:0] d1,
                               output bit g0, output bit g1);
        bit e0;
        bit e1;
        bit r1;
        @(posedge clk_clk); #1;
        if (!m0_pend) begin
            m0_req = n0;
            if (n0) m0_addr = a0;
            m0_pend = n0;
        end
        if (!m1_pend) begin
            m1_req = n1;
            if (n1) begin m1_write = w1; m1_addr = a1; m1_wdata = d1; end
            m1_pend = n1;
        end
        @(negedge clk_clk);
        r1 = m1_pend;
        e0 = 1'b0;
        e1 = 1'b0;
        if (m0_pend && m1_pend) begin
`ifdef TTY_ARB_RR_EN
            if (last_host) e0 = 1'b1; else e1 = 1'b1;
`else
            if (streak == STARVE_MAX) e1 = 1'b1; else e0 = 1'b1;
`endif
        end else begin
            e0 = m0_pend;
            e1 = m1_pend;
        end
        check("m0_gnt", m0_gnt, e0);
        check("m1_gnt", m1_gnt, e1);
        g0 = m0_gnt;
        g1 = m1_gnt;
        if (e0) begin
            q0.push_back('{due: cyc + 1 + RD_LAT, data: ref_mem[m0_addr]});
            qc.push_back('{due: cyc + 1, wr: 1'b0, addr: m0_addr, wd: 8'h00});
            m0_pend = 1'b0;
            last_host = 1'b0;
        end
        if (e1) begin
            qc.push_back('{due: cyc + 1, wr: m1_write, addr: m1_addr, wd: m1_wdata});
            if (m1_write) ref_mem[m1_addr] = m1_wdata;
            else q1.push_back('{due: cyc + 1 + RD_LAT, data: ref_mem[m1_addr]});
            m1_pend = 1'b0;
            last_host = 1'b1;
        end
        if (!r1 || e1) streak = 0;
        else if (e0) streak++;
    endtask

    task automatic idle(input int n);
        bit g0;
        bit g1;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, g0, g1);
    endtask

    // Reset with M0 requesting; all outputs must stay low, clken rises after release
    task automatic do_reset();
        @(posedge clk_clk); #1;
        reset_reset_n = 1'b0;
        m0_req = 1'b1;
        m1_req = 1'b0;
        m0_pend = 1'b0;
        m1_pend = 1'b0;
        q0.delete(); q1.delete(); qc.delete();
        streak = 0;
        last_host = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_clk);
            check("reset_outputs",
                  {m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata, ram_address,
                   ram_chipselect, ram_clken, ram_write, ram_writedata}, 64'h0);
        end
        @(posedge clk_clk); #1;
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        check("clken_before_first_clock", ram_clken, 1'b0);
        check("gnt_before_first_clock", {m0_gnt, m1_gnt}, 2'b00);
        @(posedge clk_clk); #1;
        m0_req = 1'b0;
        @(negedge clk_clk);
        check("clken_after_release", ram_clken, 1'b1);
    endtask

    initial begin
        bit g0;
        bit g1;
        logic [7:0] v;
        for (int i = 0; i < 65536; i++) begin
            v = 8'(i * 7 + 3);
            ram_mem[i] = v;
            ref_mem[i] = v;
        end
        for (int i = 0; i < 3; i++) begin
            ram_mem[i] = 8'h41 + 8'(i);
            ref_mem[i] = 8'h41 + 8'(i);
        end
        for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = 8'h00;

        do_reset();

        // M0 back-to-back reads of the preloaded text
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 16'(i), 1'b0, 1'b0, 16'h0, 8'h0, g0, g1);
        idle(3);

        // M1 write then read of the same address
        drive_cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h1234, 8'h5A, g0, g1);
        drive_cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h1234, 8'h00, g0, g1);
        idle(4);
        check("m1_rdata_hold", m1_rdata, 8'h5A);

        // Random mixed traffic, biased to a small address window
        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom % 100) < 60,
                        ($urandom % 4 == 0) ? 16'($urandom) : 16'($urandom_range(0, 15)),
                        ($urandom % 100) < 50, 1'($urandom),
                        ($urandom % 4 == 0) ? 16'($urandom) : 16'($urandom_range(0, 15)),
                        8'($urandom), g0, g1);
        end
        idle(6);

        // Both masters continuously requesting from a clean reset
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive_cycle(1'b1, 16'($urandom_range(0, 15)), 1'b1, 1'($urandom),
                        16'($urandom_range(0, 15)), 8'($urandom), g0, g1);
            check("both_gnt_exclusive", {g0, g1}, {~g1, g1});
`ifdef TTY_ARB_RR_EN
            check("rr_pattern_m1", g1, (i % 2) == 1);
`else
            check("starve_pattern_m1", g1, (i % 16) == 15);
`endif
        end
        idle(6);

        // Reset one cycle after an M0 read grant: the read must be dropped
        drive_cycle(1'b1, 16'h0002, 1'b0, 1'b0, 16'h0, 8'h0, g0, g1);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, g0, g1);
            check("no_rvalid_after_reset", {m0_rvalid, m1_rvalid}, 2'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
